// File: rtl/wait_delay_timer.sv
// rtl/wait_delay_timer.sv - randomised WAIT-state countdown with false-start flags
module wait_delay_timer #(
  parameter int         CLK_PER_MS   = 50000,
  parameter int         MIN_DELAY_MS = 1000,
  parameter int         MAX_DELAY_MS = 5000,
  parameter logic [2:0] WAIT_CODE    = 3'd1,
  parameter logic [2:0] IDLE_CODE    = 3'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  machine_state,
  input  logic [13:0] rand_num,
  input  logic        key_a,
  input  logic        key_b,
  output logic        delay_busy,
  output logic        delay_done,
  output logic [13:0] remaining_ms,
  output logic [1:0]  false_start
);

  localparam int              PW       = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [13:0]     MIN_MS   = 14'(MIN_DELAY_MS);
  localparam logic [13:0]     MAX_MS   = 14'(MAX_DELAY_MS);

  logic [PW-1:0] prescaler;
  logic [2:0]    prev_state;
  logic          in_wait;
  logic          entry;
  logic [13:0]   clamped;
  logic [1:0]    fs_set;
  logic          fs_clear;

  always_comb begin
    in_wait  = (machine_state == WAIT_CODE);
    entry    = in_wait && (prev_state != WAIT_CODE);
    clamped  = rand_num;
    if (rand_num < MIN_MS) begin
      clamped = MIN_MS;
    end else if (rand_num > MAX_MS) begin
      clamped = MAX_MS;
    end
    fs_set   = in_wait ? {key_a, key_b} : 2'b00;
    fs_clear = entry || (machine_state == IDLE_CODE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prescaler    <= '0;
      prev_state   <= IDLE_CODE;
      delay_busy   <= 1'b0;
      delay_done   <= 1'b0;
      remaining_ms <= 14'd0;
      false_start  <= 2'b00;
    end else begin
      prev_state  <= machine_state;
      delay_done  <= 1'b0;
      // A press on the same cycle as a clear still registers as a false start.
      false_start <= fs_set | (fs_clear ? 2'b00 : false_start);
      if (entry) begin
        remaining_ms <= clamped;
        prescaler    <= '0;
        delay_busy   <= 1'b1;
      end else if (delay_busy && in_wait) begin
        if (prescaler != PRE_LAST) begin
          prescaler <= prescaler + 1'b1;
        end else begin
          prescaler    <= '0;
          remaining_ms <= remaining_ms - 14'd1;
          if (remaining_ms == 14'd1) begin
            delay_busy <= 1'b0;
            delay_done <= 1'b1;
          end
        end
      end else if (delay_busy) begin
        // Main FSM left WAIT early: abandon the countdown silently.
        delay_busy   <= 1'b0;
        remaining_ms <= 14'd0;
        prescaler    <= '0;
      end
    end
  end

endmodule
